// File: rtl/conv_sample_pacer.sv
// conv_sample_pacer: buffers upstream samples in a small FIFO and releases them
// to a convolution core as one-cycle strobes spaced at least GAP cycles apart.
// A zero-wait-state APB-style register port provides control and status.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   s_valid/s_data/s_ready upstream sample handshake (s_ready = !full)
//   data_out_enable        one-cycle strobe to the core's data_in_enable
//   data_out               paced sample to the core's data_in, held between strobes
//   p_sel/p_ce/p_we/p_strb/p_addr/p_wdata  register access request
//   p_rdy/p_rdata          register access response (combinational)
//
// Register map (p_addr is a word index):
//   0 CTRL     bit0 enable (rw), bit1 flush (write-1 pulse, reads 0)
//   1 GAP      bits[15:0] minimum strobe spacing, 0 treated as 1
//   2 STATUS   bits[7:0] level, bit8 empty, bit9 full, bit16 overflow (sticky, write-1 clears)
//   3 DROP_CNT saturating count of dropped samples, any write clears
module conv_sample_pacer #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned GAP_RESET     = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_valid,
  input  logic [DATA_BITWIDTH-1:0] s_data,
  output logic                     s_ready,
  output logic                     data_out_enable,
  output logic [DATA_BITWIDTH-1:0] data_out,
  input  logic                     p_sel,
  input  logic                     p_ce,
  input  logic                     p_we,
  input  logic [3:0]               p_strb,
  input  logic [31:0]              p_addr,
  input  logic [31:0]              p_wdata,
  output logic                     p_rdy,
  output logic [31:0]              p_rdata
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic [31:0] IDX_CTRL   = 32'd0;
  localparam logic [31:0] IDX_GAP    = 32'd1;
  localparam logic [31:0] IDX_STATUS = 32'd2;
  localparam logic [31:0] IDX_DROP   = 32'd3;

  logic [DATA_BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W-1:0]         level;
  logic                     empty;
  logic                     full;

  logic                     enable_q;
  logic [15:0]              gap_q;
  logic                     overflow_q;
  logic [31:0]              drop_cnt_q;
  logic [CNT_W-1:0]         gap_cnt_q;
  logic [CNT_W-1:0]         gap_eff;

  logic                     wr_access;
  logic                     wr_ctrl;
  logic                     wr_gap;
  logic                     wr_status;
  logic                     wr_drop;
  logic                     flush;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic [31:0]              status_word;
  logic                     unused_apb;

  // FIFO occupancy from pointers carrying one extra wrap bit
  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == PTR_W'(FIFO_DEPTH));

  assign s_ready = !full;

  // Register write decode
  assign wr_access = p_sel & p_ce & p_we;
  assign wr_ctrl   = wr_access & (p_addr == IDX_CTRL);
  assign wr_gap    = wr_access & (p_addr == IDX_GAP);
  assign wr_status = wr_access & (p_addr == IDX_STATUS);
  assign wr_drop   = wr_access & (p_addr == IDX_DROP);
  assign flush     = wr_ctrl & p_strb[0] & p_wdata[1];

  // Flush wins over both push and pop on its edge
  assign push    = s_valid & !full & !flush;
  assign drop    = s_valid & full;
  assign pop     = enable_q & !empty & (gap_cnt_q == '0) & !flush;
  assign gap_eff = (gap_q == '0) ? CNT_W'(1) : gap_q;

  assign unused_apb = ^{p_wdata[31:17], p_strb[3]};

  // Sample storage; contents are don't-care while empty so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= s_data;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Emission: head of FIFO registered onto data_out with a one-cycle strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out_enable <= 1'b0;
      data_out        <= '0;
    end else begin
      data_out_enable <= pop;
      if (pop) begin
        data_out <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  // Gap counter; GAP is sampled only when it reloads on an emission
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_cnt_q <= '0;
    end else if (!enable_q || flush) begin
      gap_cnt_q <= '0;
    end else if (pop) begin
      gap_cnt_q <= gap_eff - CNT_W'(1);
    end else if (gap_cnt_q != '0) begin
      gap_cnt_q <= gap_cnt_q - CNT_W'(1);
    end
  end

  // CTRL and GAP registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable_q <= 1'b0;
      gap_q    <= 16'(GAP_RESET);
    end else begin
      if (wr_ctrl && p_strb[0]) enable_q <= p_wdata[0];
      if (wr_gap && p_strb[0])  gap_q[7:0]  <= p_wdata[7:0];
      if (wr_gap && p_strb[1])  gap_q[15:8] <= p_wdata[15:8];
    end
  end

  // Overflow flag and drop counter; a drop wins over a same-edge clear of the flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (wr_status && p_strb[2] && p_wdata[16]) begin
        overflow_q <= 1'b0;
      end
      if (wr_drop) begin
        drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 32'd1;
      end
    end
  end

  assign status_word = {15'b0, overflow_q, 6'b0, full, empty, 8'(level)};

  assign p_rdy = p_sel & p_ce;

  // Read mux
  always_comb begin
    p_rdata = '0;
    if (p_sel) begin
      case (p_addr)
        IDX_CTRL:   p_rdata = {31'b0, enable_q};
        IDX_GAP:    p_rdata = {16'b0, gap_q};
        IDX_STATUS: p_rdata = status_word;
        IDX_DROP:   p_rdata = drop_cnt_q;
        default:    p_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sample_pacer.sv
module tb_conv_sample_pacer;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rstn;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          data_out_enable;
  logic [DW-1:0] data_out;
  logic          p_sel;
  logic          p_ce;
  logic          p_we;
  logic [3:0]    p_strb;
  logic [31:0]   p_addr;
  logic [31:0]   p_wdata;
  logic          p_rdy;
  logic [31:0]   p_rdata;

  conv_sample_pacer #(
    .DATA_BITWIDTH(DW),
    .FIFO_DEPTH   (DEPTH),
    .GAP_RESET    (32)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .data_out_enable(data_out_enable),
    .data_out       (data_out),
    .p_sel          (p_sel),
    .p_ce           (p_ce),
    .p_we           (p_we),
    .p_strb         (p_strb),
    .p_addr         (p_addr),
    .p_wdata        (p_wdata),
    .p_rdy          (p_rdy),
    .p_rdata        (p_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } strobe_t;

  strobe_t strb_q[$];

  always @(posedge clk) cyc++;

  // Record every strobe with the index of the edge that produced it
  always @(posedge clk) begin
    #1;
    if (rstn && data_out_enable) strb_q.push_back('{cyc, data_out});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    s_valid = 1'b0; s_data = '0;
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_strb = 4'h0; p_addr = '0; p_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    strb_q.delete();
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b1; p_addr = addr; p_wdata = data; p_strb = strb;
    tick();
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_strb = 4'h0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    p_sel = 1'b1; p_ce = 1'b1; p_we = 1'b0; p_addr = addr;
    #1;
    check("p_rdy_during_read", 32'(p_rdy), 32'd1);
    data = p_rdata;
    @(posedge clk);
    #1;
    p_sel = 1'b0; p_ce = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(addr, d);
    check(name, d, exp);
  endtask

  // Offers one sample for one edge; returns the edge index it was offered on
  task automatic push_sample(input logic [DW-1:0] d, output int edge_idx);
    s_valid = 1'b1; s_data = d;
    tick();
    edge_idx = cyc;
    s_valid = 1'b0;
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic test_registers();
    vec_t v [15];
    logic [31:0] d;
    v[0]  = '{1'b0, 32'd1, 32'h0,        4'hF, 32'h20,   "gap_reset"};
    v[1]  = '{1'b0, 32'd0, 32'h0,        4'hF, 32'h0,    "ctrl_reset"};
    v[2]  = '{1'b0, 32'd2, 32'h0,        4'hF, 32'h100,  "status_reset"};
    v[3]  = '{1'b0, 32'd3, 32'h0,        4'hF, 32'h0,    "drop_reset"};
    v[4]  = '{1'b1, 32'd1, 32'h5,        4'hF, 32'h5,    "gap_write5"};
    v[5]  = '{1'b0, 32'd7, 32'h0,        4'hF, 32'h0,    "idx7_read"};
    v[6]  = '{1'b1, 32'd7, 32'hFFFFFFFF, 4'hF, 32'h0,    "idx7_write"};
    v[7]  = '{1'b1, 32'd1, 32'h0000AB12, 4'h2, 32'hAB05, "gap_lane1"};
    v[8]  = '{1'b1, 32'd1, 32'h00000034, 4'h1, 32'hAB34, "gap_lane0"};
    v[9]  = '{1'b1, 32'd1, 32'hFFFF0007, 4'hF, 32'h7,    "gap_upper"};
    v[10] = '{1'b1, 32'd0, 32'h2,        4'hF, 32'h0,    "ctrl_flush_reads0"};
    v[11] = '{1'b1, 32'd0, 32'h1,        4'hF, 32'h1,    "ctrl_enable"};
    v[12] = '{1'b1, 32'd0, 32'h0,        4'hE, 32'h1,    "ctrl_strb_gated"};
    v[13] = '{1'b1, 32'd0, 32'h0,        4'hF, 32'h0,    "ctrl_disable"};
    v[14] = '{1'b1, 32'd2, 32'hFFFFFFFF, 4'hF, 32'h100,  "status_readonly"};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (v[i].we) apb_write(v[i].addr, v[i].wdata, v[i].strb);
      apb_read(v[i].addr, d);
      check(v[i].name, d, v[i].exp);
    end
    // Idle bus reads zero and is not ready
    p_sel = 1'b0; p_ce = 1'b1; p_addr = 32'd1;
    #1;
    check("idle_rdata", p_rdata, 32'h0);
    check("idle_rdy", 32'(p_rdy), 32'h0);
    p_ce = 1'b0;
    tick();
  endtask

  task automatic test_pacing();
    int acc0, e;
    do_reset();
    apb_write(32'd1, 32'd32, 4'hF);
    apb_write(32'd0, 32'd1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      push_sample(16'(16'h1000 + i), e);
      if (i == 0) acc0 = e;
    end
    repeat (120) tick();
    check("pace_count", 32'(strb_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < strb_q.size(); i++) begin
      check("pace_data", 32'(strb_q[i].data), 32'(16'h1000 + i));
      check("pace_cycle", 32'(strb_q[i].cyc - acc0), 32'(1 + 32 * i));
    end
  endtask

  task automatic test_overflow();
    int e;
    do_reset();
    for (int i = 0; i < 18; i++) push_sample(16'(i), e);
    check("ovf_s_ready_low", 32'(s_ready), 32'd0);
    read_check("ovf_status", 32'd2, 32'h0001_0210);
    read_check("ovf_drop", 32'd3, 32'd2);
    apb_write(32'd2, 32'h0001_0000, 4'hF);
    read_check("ovf_cleared_status", 32'd2, 32'h0000_0210);
    read_check("ovf_drop_kept", 32'd3, 32'd2);
    // Full with a pop on the same edge still refuses the offered sample
    apb_write(32'd1, 32'd1, 4'hF);
    apb_write(32'd0, 32'd1, 4'hF);
    s_valid = 1'b1; s_data = 16'hBEEF;
    #1;
    check("full_pop_s_ready", 32'(s_ready), 32'd0);
    tick();
    s_valid = 1'b0;
    repeat (25) tick();
    check("drain_count", 32'(strb_q.size()), 32'd16);
    for (int i = 0; i < strb_q.size(); i++) begin
      check("drain_data", 32'(strb_q[i].data), 32'(i));
      if (i > 0) check("drain_spacing", 32'(strb_q[i].cyc - strb_q[i-1].cyc), 32'd1);
    end
    read_check("full_pop_drop", 32'd3, 32'd3);
    apb_write(32'd3, 32'h0, 4'h0);
    read_check("drop_clear", 32'd3, 32'd0);
  endtask

  task automatic test_flush();
    int e;
    do_reset();
    for (int i = 0; i < 10; i++) push_sample(16'(16'h4000 + i), e);
    read_check("flush_pre_status", 32'd2, 32'h0000_000A);
    s_valid = 1'b1; s_data = 16'h4FFF;
    apb_write(32'd0, 32'h3, 4'hF);
    s_valid = 1'b0;
    read_check("flush_status_empty", 32'd2, 32'h0000_0100);
    repeat (50) tick();
    check("flush_no_strobes", 32'(strb_q.size()), 32'd0);
    read_check("flush_ctrl", 32'd0, 32'd1);
    read_check("flush_drop", 32'd3, 32'd0);
  endtask

  task automatic test_wrap();
    int acc0, e;
    do_reset();
    apb_write(32'd1, 32'd0, 4'hF);
    apb_write(32'd0, 32'd1, 4'hF);
    for (int i = 0; i < 40; i++) begin
      push_sample(16'(16'h2000 + i), e);
      if (i == 0) acc0 = e;
    end
    repeat (10) tick();
    check("wrap_count", 32'(strb_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < strb_q.size(); i++) begin
      check("wrap_data", 32'(strb_q[i].data), 32'(16'h2000 + i));
      check("wrap_cycle", 32'(strb_q[i].cyc - acc0), 32'(1 + i));
    end
    read_check("wrap_drop", 32'd3, 32'd0);
    read_check("wrap_status", 32'd2, 32'h0000_0100);
  endtask

  task automatic test_async_reset();
    int e;
    do_reset();
    apb_write(32'd1, 32'd10, 4'hF);
    apb_write(32'd0, 32'd1, 4'hF);
    for (int i = 0; i < 6; i++) push_sample(16'(16'h3001 + i), e);
    repeat (3) tick();
    check("pre_reset_data", 32'(data_out), 32'h3001);
    p_sel = 1'b1; p_ce = 1'b0; p_we = 1'b0; p_addr = 32'd2;
    #3;
    rstn = 1'b0;
    #1;
    check("async_data_out", 32'(data_out), 32'h0);
    check("async_strobe", 32'(data_out_enable), 32'h0);
    check("async_s_ready", 32'(s_ready), 32'h1);
    check("async_status", p_rdata, 32'h0000_0100);
    p_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    strb_q.delete();
    repeat (40) tick();
    check("post_reset_no_strobe", 32'(strb_q.size()), 32'd0);
    read_check("post_reset_ctrl", 32'd0, 32'd0);
    read_check("post_reset_gap", 32'd1, 32'd32);
  endtask

  // Randomized traffic against a timestamp-based model: a sample may leave at
  // edge t only if enabled, queued, and t has reached the earliest time allowed
  // by the GAP in force at the previous emission.
  task automatic test_random(input int n);
    logic [DW-1:0] q[$];
    int            next_ok;
    bit            en_m;
    logic [15:0]   gap_m;
    int            drops;
    logic [DW-1:0] last_do;
    logic [31:0]   d;
    do_reset();
    apb_write(32'd1, 32'd2, 4'hF);
    apb_write(32'd0, 32'd1, 4'hF);
    en_m = 1'b1; gap_m = 16'd2; next_ok = 0; drops = 0; last_do = '0;
    for (int i = 0; i < n; i++) begin
      int            e;
      int            act;
      bit            sv, wc, wg, fl, full_pre, emit;
      logic [DW-1:0] sd;
      logic [31:0]   wd;
      e = cyc + 1;
      case ((i / 250) % 3)
        0:       sv = ($urandom_range(0, 9) != 0);
        1:       sv = ($urandom_range(0, 1) == 1);
        default: sv = ($urandom_range(0, 4) == 0);
      endcase
      sd  = DW'($urandom);
      act = int'($urandom_range(0, 39));
      wc = 1'b0; wg = 1'b0; fl = 1'b0; wd = '0;
      if (act == 0) begin
        wg = 1'b1; wd = 32'($urandom_range(0, 3));
      end else if (act == 1) begin
        wc = 1'b1; wd = {31'b0, ($urandom_range(0, 3) != 0)};
      end else if (act == 2) begin
        wc = 1'b1; fl = 1'b1; wd = 32'h3;
      end
      s_valid = sv; s_data = sd;
      p_sel = wc | wg; p_ce = wc | wg; p_we = wc | wg;
      p_addr = wg ? 32'd1 : 32'd0; p_wdata = wd; p_strb = 4'hF;
      #1;
      check("rnd_s_ready", 32'(s_ready), 32'(q.size() < DEPTH));
      full_pre = (q.size() == DEPTH);
      emit = en_m && !fl && (q.size() > 0) && (e >= next_ok);
      if (emit) begin
        last_do = q.pop_front();
        next_ok = e + ((gap_m == 16'd0) ? 1 : int'(gap_m));
      end else if (!en_m || fl) begin
        next_ok = e + 1;
      end
      if (fl) q.delete();
      if (sv && !full_pre && !fl) q.push_back(sd);
      if (sv && full_pre) drops++;
      if (wc) en_m = wd[0];
      if (wg) gap_m = wd[15:0];
      tick();
      check("rnd_strobe", 32'(data_out_enable), 32'(emit));
      check("rnd_data_out", 32'(data_out), 32'(last_do));
    end
    s_valid = 1'b0;
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0;
    apb_read(32'd3, d);
    check("rnd_drop_cnt", d, 32'(drops));
    apb_read(32'd2, d);
    check("rnd_overflow", 32'(d[16]), 32'(drops > 0));
  endtask

  initial begin
    rstn = 1'b0;
    s_valid = 1'b0; s_data = '0;
    p_sel = 1'b0; p_ce = 1'b0; p_we = 1'b0; p_strb = 4'h0; p_addr = '0; p_wdata = '0;
    @(posedge clk);
    #1;
    test_registers();
    test_pacing();
    test_overflow();
    test_flush();
    test_wrap();
    test_async_reset();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sample_pacer.md
CONV_SAMPLE_PACER -- requirements
Module: conv_sample_pacer

Interface
- REQ-001 SHALL have parameter DATA_BITWIDTH, default 16: sample width.
- REQ-002 SHALL have parameter FIFO_DEPTH, default 16: sample buffer depth, power of 2, at least 2.
- REQ-003 SHALL have parameter GAP_RESET, default 32: reset value of the GAP register, matching 2*CONV_CORE_DEPTH of the downstream core.
- REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
- REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
- REQ-006 SHALL have port s_valid, input, 1 bit: an upstream sample is offered.
- REQ-007 SHALL have port s_data, input, DATA_BITWIDTH bits: the upstream sample.
- REQ-008 SHALL have port s_ready, output, 1 bit: equals !full, so a sample will be accepted.
- REQ-009 SHALL have port data_out_enable, output, 1 bit: one-cycle strobe that feeds data_in_enable of the convolution core.
- REQ-010 SHALL have port data_out, output, DATA_BITWIDTH bits: paced sample that feeds data_in of the convolution core.
- REQ-011 SHALL have APB-style ports p_sel, p_ce, p_we (input, 1 bit), p_strb (input, 4 bits), and p_addr, p_wdata (input, 32 bits).
- REQ-012 SHALL have APB-style ports p_rdy (output, 1 bit) and p_rdata (output, 32 bits).

Function
- REQ-013 SHALL decode p_addr as a word index: 0 = CTRL, 1 = GAP, 2 = STATUS, 3 = DROP_CNT; other indexes read 0 and ignore writes.
- REQ-014 SHALL drive p_rdy = p_sel & p_ce combinationally (zero wait states).
- REQ-015 SHALL commit a write on the rising edge where p_sel & p_ce & p_we; p_strb byte lanes gate each byte.
- REQ-016 SHALL drive p_rdata combinationally from p_addr while p_sel is high, and 0 otherwise.
- REQ-017 SHALL implement CTRL bit0 enable (read/write) and CTRL bit1 flush (write-1, self-clearing, always reads 0).
- REQ-018 SHALL implement GAP bits[15:0] (read/write) as the minimum number of cycles between data_out_enable strobes; a GAP value of 0 is treated as 1.
- REQ-019 SHALL implement STATUS as read-only: bits[7:0] level, bit8 empty, bit9 full, bit16 overflow (sticky).
- REQ-020 SHALL clear STATUS bit16 (overflow) when 1 is written to STATUS bit16; all other STATUS bits ignore writes.
- REQ-021 SHALL implement DROP_CNT as a read-only 32-bit count of dropped samples that saturates at 0xFFFFFFFF; any write to DROP_CNT clears it.
- REQ-022 SHALL accept a sample (push) on an edge where s_valid & s_ready.
- REQ-023 SHALL drop a sample offered with s_valid & !s_ready, and on that edge set overflow and increment DROP_CNT.
- REQ-024 SHALL keep s_ready low when full even if a pop happens on the same edge; that sample is dropped.
- REQ-025 SHALL keep a gap counter: it loads GAP-1 on each emission, decrements by 1 per cycle while nonzero, and otherwise holds at 0.
- REQ-026 SHALL emit on an edge where enable & !empty & counter==0: pop the head, register it onto data_out, and drive data_out_enable high for exactly one cycle.
- REQ-027 SHALL hold data_out after an emission until the next emission.
- REQ-028 SHALL raise data_out_enable in the cycle after the emitting edge, and emit one edge after acceptance when the FIFO is empty, enable is 1, and the counter is 0.
- REQ-029 SHALL space strobes exactly max(GAP,1) cycles apart while the FIFO stays non-empty.
- REQ-030 SHALL allow a push and a pop on the same edge when the FIFO is not full; the level is then unchanged.
- REQ-031 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with no loss or reordering of samples.
- REQ-032 SHALL, on flush, empty the FIFO on the write edge, discard any push on that edge, and zero the counter; overflow and DROP_CNT are unchanged by flush.
- REQ-033 SHALL, while enable is 0, emit nothing, retain the FIFO contents, force the counter to 0, and keep accepting pushes.
- REQ-034 SHALL apply a GAP write made mid-count only at the next counter reload.

Reset
- REQ-035 SHALL, while rstn is low, clear the FIFO to empty and set data_out_enable=0, data_out=0, s_ready=1, and counter=0.
- REQ-036 SHALL, while rstn is low, set CTRL=0 (disabled), GAP=GAP_RESET, overflow=0, and DROP_CNT=0.
- REQ-037 SHALL abandon any pending emission when rstn is asserted mid-operation, leaving no strobe afterwards until it is re-enabled.

Verification
- REQ-038 SHALL verify register access: write GAP=5 at index 1, then read index 1 -> 0x00000005 with p_rdy high in the access cycle; read index 7 -> 0.
- REQ-039 SHALL verify pacing: enable, GAP=32, push 4 samples back-to-back (0x1000..0x1003) -> 4 strobes exactly 32 cycles apart, in order, the first one cycle after the first acceptance.
- REQ-040 SHALL verify overflow: with enable=0, push 18 samples at FIFO_DEPTH=16 -> STATUS reads full=1, level=16, overflow=1, and DROP_CNT reads 2.
- REQ-041 SHALL verify overflow clear: then write 0x10000 to STATUS -> overflow reads 0 while DROP_CNT still reads 2.
- REQ-042 SHALL verify flush: hold 10 samples, write CTRL=0x3 -> STATUS shows empty=1 the next cycle and no strobes follow.
- REQ-043 SHALL verify wrap-around: enable with GAP=0 and stream 40 samples at 1 per cycle -> 40 strobes on consecutive cycles, data in order, no drops.
- REQ-044 SHALL verify reset mid-operation: assert rstn with 5 samples queued -> outputs go to their reset values asynchronously, STATUS reads empty, and no strobe follows after release.
